// File: rtl/blink_pkg.sv
// ============================================================================
// blink_pkg : shared types and constants for the multi-channel blinker
// Rev 1.0
// ============================================================================
`default_nettype none

package blink_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_FIXED  = 2'd1,
      MODE_RANDOM = 2'd2,
      MODE_TOGGLE = 2'd3
   } mode_e;

   // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   localparam int DEFAULT_INTERVAL = 10;

endpackage

`default_nettype wire

// File: rtl/blink_lfsr.sv
// ============================================================================
// blink_lfsr : free-running Galois LFSR supplying jitter to all channels
// Rev 1.0
// ============================================================================
`default_nettype none

module blink_lfsr
   import blink_pkg::*;
#(
   parameter int unsigned           LFSR_W    = 16,
   parameter logic [LFSR_W-1:0]     LFSR_SEED = LFSR_W'(16'hACE1)
) (
   input  logic              clk,
   input  logic              rstbtn,
   output logic [LFSR_W-1:0] state
);

   localparam logic [LFSR_W-1:0] c_MASK = LFSR_W'(LFSR_MASK);
   // An all-zero seed would lock the register up
   localparam logic [LFSR_W-1:0] c_SEED = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

   logic [LFSR_W-1:0] state_q;

   always_ff @(posedge clk) begin
      if (!rstbtn) begin
         state_q <= c_SEED;
      end else begin
         state_q <= {1'b0, state_q[LFSR_W-1:1]} ^ (state_q[0] ? c_MASK : '0);
      end
   end

   assign state = state_q;

endmodule

`default_nettype wire

// File: rtl/multi_blinker.sv
// ============================================================================
// multi_blinker : N-channel LED blinker, OFF/FIXED/RANDOM/TOGGLE per channel
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_blinker
   import blink_pkg::*;
#(
   parameter int unsigned       NUM_CH           = 3,
   parameter int unsigned       CNT_W            = 8,
   parameter int unsigned       RAND_W           = 4,
   parameter int unsigned       LFSR_W           = 16,
   parameter logic [LFSR_W-1:0] LFSR_SEED        = LFSR_W'(16'hACE1),
   parameter int unsigned       DEFAULT_INTERVAL = blink_pkg::DEFAULT_INTERVAL
) (
   input  logic              clk,
   input  logic              rstbtn,
   input  logic              en,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [CNT_W-1:0]  cfg_interval,
   output logic [NUM_CH-1:0] leds,
   output logic [NUM_CH-1:0] blink_evt
);

   localparam logic [CNT_W:0] c_ONE = (CNT_W+1)'(1);

   if ((NUM_CH * RAND_W) > LFSR_W || NUM_CH < 1 || NUM_CH > 8) begin : g_bad_cfg
      $error("multi_blinker: need 1<=NUM_CH<=8 and NUM_CH*RAND_W <= LFSR_W");
   end

   function automatic logic [CNT_W:0] eff_interval(input logic [CNT_W-1:0] iv);
      return (iv == '0) ? c_ONE : {1'b0, iv};
   endfunction

   logic [LFSR_W-1:0] lfsr_state;
   logic              w_unused_lfsr;

   blink_lfsr #(
      .LFSR_W    (LFSR_W),
      .LFSR_SEED (LFSR_SEED)
   ) u_lfsr (
      .clk    (clk),
      .rstbtn (rstbtn),
      .state  (lfsr_state)
   );

   // Some LFSR bits carry no jitter for small channel counts
   assign w_unused_lfsr = ^lfsr_state;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mode_e              mode_q;
      logic [CNT_W-1:0]   ival_q;
      logic [CNT_W:0]     cnt_q;
      logic [CNT_W:0]     per_q;
      logic               led_q;
      logic               evt_q;

      logic               wr_hit;
      logic               evt_hit;
      logic [CNT_W:0]     rnd_ext;
      logic [CNT_W:0]     wr_per_d;
      logic [CNT_W:0]     ev_per_d;

      always_comb begin
         rnd_ext  = {{(CNT_W+1-RAND_W){1'b0}}, lfsr_state[i*RAND_W +: RAND_W]};
         wr_hit   = cfg_we && (cfg_ch == 3'(i));
         evt_hit  = (mode_q != MODE_OFF) && en && (cnt_q == per_q - c_ONE);
         wr_per_d = eff_interval(cfg_interval)
                  + ((mode_e'(cfg_mode) == MODE_RANDOM) ? rnd_ext : '0);
         ev_per_d = eff_interval(ival_q)
                  + ((mode_q == MODE_RANDOM) ? rnd_ext : '0);
      end

      // A config write on the event edge takes priority and swallows the event
      always_ff @(posedge clk) begin
         if (!rstbtn) begin
            mode_q <= MODE_OFF;
            ival_q <= CNT_W'(DEFAULT_INTERVAL);
            cnt_q  <= '0;
            per_q  <= eff_interval(CNT_W'(DEFAULT_INTERVAL));
            led_q  <= 1'b0;
            evt_q  <= 1'b0;
         end else if (wr_hit) begin
            mode_q <= mode_e'(cfg_mode);
            ival_q <= cfg_interval;
            cnt_q  <= '0;
            per_q  <= wr_per_d;
            led_q  <= 1'b0;
            evt_q  <= 1'b0;
         end else if (mode_q == MODE_OFF) begin
            cnt_q  <= '0;
            led_q  <= 1'b0;
            evt_q  <= 1'b0;
         end else if (!en) begin
            evt_q  <= 1'b0;
         end else if (evt_hit) begin
            cnt_q  <= '0;
            per_q  <= ev_per_d;
            evt_q  <= 1'b1;
            led_q  <= (mode_q == MODE_TOGGLE) ? ~led_q : 1'b1;
         end else begin
            cnt_q  <= cnt_q + c_ONE;
            evt_q  <= 1'b0;
            if (mode_q != MODE_TOGGLE) begin
               led_q <= 1'b0;
            end
         end
      end

      assign leds[i]      = led_q;
      assign blink_evt[i] = evt_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_multi_blinker.sv
// ============================================================================
// tb_multi_blinker : directed self-checking bench for multi_blinker
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multi_blinker;

   logic       clk;
   logic       rstbtn;
   logic       en;
   logic       cfg_we;
   logic [2:0] cfg_ch;
   logic [1:0] cfg_mode;
   logic [7:0] cfg_interval;
   logic [2:0] leds;
   logic [2:0] blink_evt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] m_lfsr;

   multi_blinker dut (
      .clk          (clk),
      .rstbtn       (rstbtn),
      .en           (en),
      .cfg_we       (cfg_we),
      .cfg_ch       (cfg_ch),
      .cfg_mode     (cfg_mode),
      .cfg_interval (cfg_interval),
      .leds         (leds),
      .blink_evt    (blink_evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   always @(posedge clk) begin
      if (!rstbtn) m_lfsr <= 16'hACE1;
      else         m_lfsr <= lfsr_step(m_lfsr);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cfg_write(input logic [2:0] ch, input logic [1:0] md, input logic [7:0] iv);
      cfg_we       = 1'b1;
      cfg_ch       = ch;
      cfg_mode     = md;
      cfg_interval = iv;
      @(negedge clk);
      cfg_we       = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [2:0] exp_led, input logic [2:0] exp_evt);
      check_eq({tag, "_leds"}, 32'(leds), 32'(exp_led));
      check_eq({tag, "_evt"},  32'(blink_evt), 32'(exp_evt));
   endtask

   initial begin
      logic [15:0] mp;
      int          p, k, c, last_c, min_iv, max_iv;
      logic        e;

      rstbtn = 1'b0; en = 1'b0; cfg_we = 1'b0;
      cfg_ch = '0; cfg_mode = '0; cfg_interval = '0;
      repeat (2) @(negedge clk);
      check_out("reset", 3'b000, 3'b000);
      check_eq("reset_lfsr", 32'(dut.lfsr_state), 32'h0000ACE1);

      rstbtn = 1'b1; en = 1'b1;

      // FIXED I=5 on ch0
      cfg_write(3'd0, 2'd1, 8'd5);
      for (int j = 1; j <= 15; j++) begin
         @(negedge clk);
         e = (j % 5 == 0);
         check_out("fixed", {2'b00, e}, {2'b00, e});
      end
      cfg_write(3'd0, 2'd0, 8'd5);
      check_out("off0", 3'b000, 3'b000);

      // TOGGLE I=3 on ch1: 3 high / 3 low
      cfg_write(3'd1, 2'd3, 8'd3);
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         check_out("toggle", {1'b0, ((j / 3) % 2 == 1), 1'b0}, {1'b0, (j % 3 == 0), 1'b0});
      end
      cfg_write(3'd1, 2'd0, 8'd3);
      check_out("off1", 3'b000, 3'b000);

      // RANDOM I=4 on ch2, period = 4 + lfsr[11:8] at period start
      p = 4 + int'(m_lfsr[11:8]);
      cfg_write(3'd2, 2'd2, 8'd4);
      k = 0; c = 0; last_c = 0; min_iv = 1000; max_iv = 0;
      for (int j = 1; j <= 200; j++) begin
         mp = m_lfsr;
         @(negedge clk);
         k++; c++;
         e = (k == p);
         check_out("random", {e, 2'b00}, {e, 2'b00});
         if (j % 20 == 0) check_eq("random_lfsr", 32'(dut.lfsr_state), 32'(m_lfsr));
         if (blink_evt[2]) begin
            if (c - last_c < min_iv) min_iv = c - last_c;
            if (c - last_c > max_iv) max_iv = c - last_c;
            last_c = c;
         end
         if (e) begin
            k = 0;
            p = 4 + int'(mp[11:8]);
         end
      end
      check_eq("random_min_ge4", 32'(min_iv >= 4), 32'd1);
      check_eq("random_max_le19", 32'(max_iv <= 19), 32'd1);
      check_eq("random_varies", 32'(max_iv != min_iv), 32'd1);
      cfg_write(3'd2, 2'd0, 8'd4);

      // Freeze: en low for 7 edges with cnt=2
      cfg_write(3'd0, 2'd1, 8'd5);
      for (int j = 1; j <= 16; j++) begin
         if (j == 3)  en = 1'b0;
         if (j == 10) en = 1'b1;
         @(negedge clk);
         check_out("freeze", {2'b00, (j == 12)}, {2'b00, (j == 12)});
         check_eq("freeze_lfsr", 32'(dut.lfsr_state), 32'(m_lfsr));
      end

      // Write lands on ch0's event edge: no pulse, count restarts
      cfg_write(3'd0, 2'd1, 8'd5);
      check_out("coll_write", 3'b000, 3'b000);
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         check_out("coll_restart", {2'b00, (j == 5)}, {2'b00, (j == 5)});
      end

      // I=0 behaves as I=1
      cfg_write(3'd0, 2'd1, 8'd0);
      check_out("i0_write", 3'b000, 3'b000);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         check_out("i0_run", 3'b001, 3'b001);
      end

      // Out-of-range channel writes are ignored
      cfg_write(3'd7, 2'd3, 8'd2);
      check_out("ch7_ignored", 3'b001, 3'b001);
      cfg_write(3'd3, 2'd2, 8'd9);
      check_out("ch3_ignored", 3'b001, 3'b001);
      repeat (2) begin
         @(negedge clk);
         check_out("after_ignored", 3'b001, 3'b001);
      end

      // Mid-run reset dominating a write and en
      cfg_write(3'd1, 2'd3, 8'd3);
      repeat (4) @(negedge clk);
      check_out("pre_reset", 3'b011, 3'b001);
      rstbtn = 1'b0;
      cfg_we = 1'b1; cfg_ch = 3'd0; cfg_mode = 2'd3; cfg_interval = 8'd2;
      @(negedge clk);
      cfg_we = 1'b0; rstbtn = 1'b1;
      check_out("midreset", 3'b000, 3'b000);
      check_eq("midreset_lfsr", 32'(dut.lfsr_state), 32'h0000ACE1);
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         check_out("modes_off", 3'b000, 3'b000);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
